// File: rtl/mnist_infer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mnist_infer_ctrl
// Brief    : Sequencer around the MNIST inference engine. It clears and starts
//            the engine, waits for done with a timeout, then scans the 10
//            class scores and holds the argmax until the host acknowledges.
// Revision : 1.0
// ============================================================================
module mnist_infer_ctrl #(
    parameter int DATA_WIDTH     = 5,
    parameter int NUM_CLASSES    = 10,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req,
    input  logic                         ack,
    output logic                         busy,
    output logic                         result_valid,
    output logic [3:0]                   result_class,
    output logic signed [DATA_WIDTH-1:0] result_score,
    output logic                         timeout_err,
    output logic                         eng_reset,
    output logic                         eng_start,
    input  logic                         eng_done,
    output logic [3:0]                   eng_out_idx,
    input  logic signed [DATA_WIDTH-1:0] eng_out
);

    localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [3:0]         c_idx_last = 4'(NUM_CLASSES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_SCAN   = 3'd4,
        S_RESULT = 3'd5
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_better;

    // Index 0 seeds the running max; afterwards only a strictly larger score
    // replaces it, so ties keep the lowest index.
    assign w_better = (eng_out_idx == 4'd0) || (eng_out > result_score);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_class <= 4'd0;
            result_score <= '0;
            timeout_err  <= 1'b0;
            eng_reset    <= 1'b0;
            eng_start    <= 1'b0;
            eng_out_idx  <= 4'd0;
        end else begin
            eng_reset <= 1'b0;
            eng_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_state   <= S_CLEAR;
                        busy      <= 1'b1;
                        eng_reset <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_state   <= S_START;
                    eng_start <= 1'b1;
                end
                S_START: begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + c_cnt_one;
                    if (eng_done) begin
                        r_state     <= S_SCAN;
                        eng_out_idx <= 4'd0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state      <= S_RESULT;
                        result_valid <= 1'b1;
                        timeout_err  <= 1'b1;
                        result_class <= 4'hF;
                        result_score <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_better) begin
                        result_class <= eng_out_idx;
                        result_score <= eng_out;
                    end
                    if (eng_out_idx == c_idx_last) begin
                        r_state      <= S_RESULT;
                        result_valid <= 1'b1;
                        eng_out_idx  <= 4'd0;
                    end else begin
                        eng_out_idx <= eng_out_idx + 4'd1;
                    end
                end
                S_RESULT: begin
                    if (ack) begin
                        r_state      <= S_IDLE;
                        busy         <= 1'b0;
                        result_valid <= 1'b0;
                        timeout_err  <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                    timeout_err  <= 1'b0;
                    eng_out_idx  <= 4'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mnist_infer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mnist_infer_ctrl
// Brief    : Self-checking bench for mnist_infer_ctrl with a behavioural
//            engine stand-in and an argmax reference model.
// Revision : 1.0
// ============================================================================
module tb_mnist_infer_ctrl;

    localparam int DW = 5;
    localparam int NC = 10;
    localparam int TO = 64;

    logic                 clk = 1'b0;
    logic                 rst, req, ack, eng_done;
    logic                 busy, result_valid, timeout_err, eng_reset, eng_start;
    logic [3:0]           result_class, eng_out_idx;
    logic signed [DW-1:0] result_score, eng_out;
    logic signed [DW-1:0] scores [16];

    int checks   = 0;
    int failures = 0;
    int t_rst, t_start, t_valid, n_rst, n_start, busy_bad, b0;

    typedef struct {
        int delay;
        int exp_class;
        int exp_score;
        bit exp_to;
    } vec_t;

    vec_t vt [6];
    int   vs [6][10];

    always #5 clk = ~clk;

    // Engine score mux: combinational from the selected index.
    assign eng_out = scores[eng_out_idx];

    mnist_infer_ctrl #(
        .DATA_WIDTH    (DW),
        .NUM_CLASSES   (NC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .ack         (ack),
        .busy        (busy),
        .result_valid(result_valid),
        .result_class(result_class),
        .result_score(result_score),
        .timeout_err (timeout_err),
        .eng_reset   (eng_reset),
        .eng_start   (eng_start),
        .eng_done    (eng_done),
        .eng_out_idx (eng_out_idx),
        .eng_out     (eng_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int d, input int c, input int s, input bit t);
        vec_t v;
        v.delay = d; v.exp_class = c; v.exp_score = s; v.exp_to = t;
        return v;
    endfunction

    task automatic load(input int k);
        for (int i = 0; i < NC; i++) scores[i] = DW'(vs[k][i]);
    endtask

    // Reference argmax: find the maximum value, then the first index holding it.
    task automatic model(output int cls, output int sc);
        int mx;
        mx = -1000;
        for (int i = 0; i < NC; i++) if (int'(scores[i]) > mx) mx = int'(scores[i]);
        cls = -1;
        for (int i = NC - 1; i >= 0; i--) if (int'(scores[i]) == mx) cls = i;
        sc = mx;
    endtask

    // Steps cycle by cycle acting as the engine; stops at result_valid or
    // when a SCAN reaches stop_idx. Cycle 0 is the first cycle after the call.
    task automatic track(input int delay, input bit stale, input bit hold,
                         input int stop_idx, output bit ok);
        bit clr_pend;
        clr_pend = 1'b0;
        t_rst = -1; t_start = -1; t_valid = -1;
        n_rst = 0; n_start = 0; busy_bad = 0; b0 = -1; ok = 1'b0;
        if (stale) eng_done = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            step();
            if (!hold) req = 1'b0;
            ack = 1'($urandom_range(0, 1));
            if (cyc == 0) b0 = int'(busy);
            if (clr_pend && !stale) eng_done = 1'b0;
            clr_pend = eng_reset;
            if (eng_reset) begin n_rst++; if (t_rst < 0) t_rst = cyc; end
            if (eng_start) begin n_start++; if (t_start < 0) t_start = cyc; end
            if (t_rst >= 0 && !busy) busy_bad++;
            if (t_start >= 0 && delay > 0 && cyc == t_start + delay) eng_done = 1'b1;
            if (result_valid) begin
                ack = 1'b0; t_valid = cyc; ok = 1'b1;
                return;
            end
            if (stop_idx >= 0 && busy && int'(eng_out_idx) == stop_idx) begin
                ack = 1'b0; ok = 1'b1;
                return;
            end
        end
        ack = 1'b0;
        checks++;
        failures++;
        $display("FAIL track_timeout: no result after 300 cycles, required result_valid");
    endtask

    task automatic check_run(input string tag, input int base, input int delay,
                             input bit stale, input bit hold, input bit rel,
                             input int ec, input int es, input bit eto);
        bit ok;
        int exp_valid;
        req = 1'b1;
        track(delay, stale, hold, -1, ok);
        if (!ok) return;
        if (delay < 0 && !stale) exp_valid = base + 2 + TO;
        else                     exp_valid = base + 1 + (stale ? 1 : delay) + 11;
        chk({tag, ":t_reset"},   t_rst,    base);
        chk({tag, ":t_start"},   t_start,  base + 1);
        chk({tag, ":t_valid"},   t_valid,  exp_valid);
        chk({tag, ":n_reset"},   n_rst,    1);
        chk({tag, ":n_start"},   n_start,  1);
        chk({tag, ":busy_drop"}, busy_bad, 0);
        if (base > 0) chk({tag, ":idle_gap_busy"}, b0, 0);
        chk({tag, ":class"},   int'(result_class), ec);
        chk({tag, ":score"},   int'(result_score), es);
        chk({tag, ":timeout"}, int'(timeout_err),  int'(eto));
        // RESULT must hold with ack low even while req is high.
        req = 1'b1; ack = 1'b0;
        step(); step();
        chk({tag, ":hold_valid"}, int'(result_valid), 1);
        chk({tag, ":hold_class"}, int'(result_class), ec);
        if (rel) begin
            ack = 1'b1; req = 1'b0;
            step();
            ack = 1'b0;
            chk({tag, ":idle_busy"},    int'(busy),         0);
            chk({tag, ":idle_valid"},   int'(result_valid), 0);
            chk({tag, ":idle_timeout"}, int'(timeout_err),  0);
            chk({tag, ":idle_class"},   int'(result_class), ec);
            chk({tag, ":idle_score"},   int'(result_score), es);
        end
    endtask

    initial begin
        bit ok;
        int ec, es, d;
        rst = 1'b1; req = 1'b0; ack = 1'b0; eng_done = 1'b0;
        for (int i = 0; i < 16; i++) scores[i] = '0;

        vs[0] = '{0, 3, -2, 7, 1, 0, -16, 5, 6, 2};              vt[0] = mk(20, 3, 7, 1'b0);
        vs[1] = '{-16, -16, -16, -16, -16, -16, -16, -16, -16, -16}; vt[1] = mk(5, 0, -16, 1'b0);
        vs[2] = '{0, 1, 2, 3, 15, -1, -5, 4, 15, 0};             vt[2] = mk(3, 4, 15, 1'b0);
        vs[3] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};                vt[3] = mk(-1, 15, 0, 1'b1);
        vs[4] = '{-3, -3, -1, -1, -8, -2, -1, -9, -4, -1};       vt[4] = mk(1, 2, -1, 1'b0);
        vs[5] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 14};                vt[5] = mk(2, 9, 14, 1'b0);

        step(); step(); step();
        chk("reset:busy",      int'(busy),         0);
        chk("reset:valid",     int'(result_valid), 0);
        chk("reset:timeout",   int'(timeout_err),  0);
        chk("reset:eng_reset", int'(eng_reset),    0);
        chk("reset:eng_start", int'(eng_start),    0);
        chk("reset:idx",       int'(eng_out_idx),  0);
        chk("reset:class",     int'(result_class), 0);
        chk("reset:score",     int'(result_score), 0);
        rst = 1'b0;
        step();

        for (int k = 0; k < 6; k++) begin
            load(k);
            check_run($sformatf("vec%0d", k), 0, vt[k].delay, 1'b0, 1'b0, 1'b1,
                      vt[k].exp_class, vt[k].exp_score, vt[k].exp_to);
        end

        // Done already high before WAIT: first WAIT cycle takes it.
        load(0);
        check_run("stale_done", 0, 20, 1'b1, 1'b0, 1'b1, 3, 7, 1'b0);

        // req held through two runs; ack and req together in RESULT.
        load(2);
        check_run("b2b_first", 0, 6, 1'b0, 1'b1, 1'b0, 4, 15, 1'b0);
        ack = 1'b1; req = 1'b1;
        check_run("b2b_second", 1, 7, 1'b0, 1'b1, 1'b1, 4, 15, 1'b0);

        // Reset in SCAN at index 5.
        load(0);
        req = 1'b1;
        track(4, 1'b0, 1'b0, 5, ok);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_scan:busy",      int'(busy),         0);
        chk("rst_scan:idx",       int'(eng_out_idx),  0);
        chk("rst_scan:valid",     int'(result_valid), 0);
        chk("rst_scan:eng_reset", int'(eng_reset),    0);
        chk("rst_scan:eng_start", int'(eng_start),    0);
        step();
        chk("rst_scan:stay_idle", int'(busy), 0);
        check_run("after_rst", 0, 9, 1'b0, 1'b0, 1'b1, 3, 7, 1'b0);

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < NC; i++)
                scores[i] = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 31))
                                                        : DW'($urandom_range(0, 3));
            d = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, 30));
            model(ec, es);
            if (d < 0) begin ec = 15; es = 0; end
            check_run($sformatf("rand%0d", r), 0, d, 1'b0, 1'b0, 1'b1, ec, es, d < 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mnist_infer_ctrl.md
Name: mnist_infer_ctrl

Overview:
- Sequencer that wraps the fixed-point MNIST inference engine (5-bit signed datapath, 10 class scores selected via a 4-bit output index).
- Accepts a classify request from the host and clears the engine, then pulses its start and waits for done with a timeout.
- Scans all 10 scores through the engine's output-index mux, computes the argmax and holds the predicted digit until the host acknowledges.
- Sits between the host/testbench and the engine top; the engine's memory port is untouched.

Parameters:
- DATA_WIDTH, 5, width of signed class scores.
- NUM_CLASSES, 10, number of scores scanned (indices 0..NUM_CLASSES-1).
- TIMEOUT_CYCLES, 1048576, maximum WAIT cycles before abort; counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  1  host classify request; level, sampled only in IDLE.
- ack  in  1  host result acknowledge; sampled only in RESULT.
- busy  out  1  high in every state except IDLE.
- result_valid  out  1  high only in RESULT.
- result_class  out  4  argmax index 0..9; 4'hF on timeout.
- result_score  out  DATA_WIDTH  signed max score; 0 on timeout.
- timeout_err  out  1  high in RESULT when WAIT expired.
- eng_reset  out  1  engine clear, one-cycle pulse.
- eng_start  out  1  engine start, one-cycle pulse.
- eng_done  in  1  engine done level; stays high until next eng_reset.
- eng_out_idx  out  4  class select to the engine.
- eng_out  in  DATA_WIDTH  signed score; combinational from eng_out_idx, valid in the same cycle.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- All outputs are registered.
- Reset values:
  - State IDLE.
  - busy, result_valid, timeout_err, eng_reset and eng_start are 0.
  - eng_out_idx = 0, result_class = 0, result_score = 0.
  - Timeout counter = 0.
- States:
  - IDLE: if req, go to CLEAR.
  - CLEAR: eng_reset=1 for exactly this cycle, then START.
  - START: eng_start=1 for exactly this cycle; clear timeout counter; go to WAIT.
  - WAIT: counter increments each cycle.
    - If eng_done, go to SCAN with eng_out_idx=0.
    - Else if counter==TIMEOUT_CYCLES-1, go to RESULT with timeout_err=1, result_class=4'hF, result_score=0.
    - If done and expiry coincide, done wins.
  - SCAN: NUM_CLASSES cycles; eng_out_idx steps 0..9, one per cycle.
    - Compare eng_out each cycle (signed) against the running max.
    - At index 0 the running max is loaded unconditionally.
    - After that, update only on strictly greater, so on ties the lowest index wins.
    - After index 9, go to RESULT; eng_out_idx returns to 0.
  - RESULT: result_valid=1; result_class, result_score and timeout_err are held stable. If ack, go to IDLE.
- Output hold rules:
  - result_class and result_score keep their value in IDLE until the next SCAN or timeout overwrites them.
  - timeout_err clears when leaving RESULT.
- Latency:
  - req seen in IDLE at cycle N: eng_reset at N+1, eng_start at N+2, WAIT from N+3.
  - eng_done first seen at cycle D: result_valid at D+11.
- Boundary conditions:
  - req while busy is ignored; no queuing.
  - ack outside RESULT is ignored.
  - req and ack both high in RESULT: go to IDLE, and the new request is taken on the next IDLE cycle.
  - eng_done already high during CLEAR/START (stale) is ignored; only WAIT samples it.
  - rst mid-operation returns to IDLE within one cycle and pulses nothing. The engine is cleared on the next request via CLEAR.
- Arithmetic: signed DATA_WIDTH compare, no widening; -16 is the minimum score.

Test Plan:
- Scores [0,3,-2,7,1,0,-16,5,6,2], done 20 cycles after start -> result_class=3, result_score=7, timeout_err=0, result_valid 11 cycles after done.
- All scores -16 -> result_class=0, result_score=-16 (tie and minimum handling).
- Scores with 15 at index 4 and index 8 -> result_class=4 (lowest index wins on tie).
- eng_done never asserted, TIMEOUT_CYCLES=64 -> RESULT after exactly 64 WAIT cycles, timeout_err=1, result_class=4'hF, result_score=0.
- req held high through a full run with ack pulsed in RESULT -> second run starts with eng_reset one cycle after returning to IDLE; eng_start is one cycle wide each run.
- rst asserted in SCAN at index 5 -> next cycle IDLE, busy=0, eng_out_idx=0, result_valid=0; a following req completes normally.
